// File: rtl/reg16_write_arbiter_pkg.sv
// Shared constants for the 16-bit register-bank write arbiter: data width,
// FSM state encoding and a constant-evaluable clog2.
package reg16_write_arbiter_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg16_write_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above ptr, with
// wraparound, returned as one-hot grant plus binary index.
module reg16_write_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/reg16_write_arbiter.sv
// Round-robin arbiter for the single write port of a 16-bit register bank,
// with locked bursts and a registered one-hot WriteEnable/data output stage.
module reg16_write_arbiter
    import reg16_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned IDX_W    = clog2(NUM_REQ)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REGS-1:0]       we,
    output logic [DATA_W-1:0]         d_out,
    output logic [IDX_W-1:0]          owner,
    output logic                      locked,
    output logic                      err_addr
);

    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REGS-1:0] we_q, we_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic                gnt_valid;
    logic [IDX_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_lock;
    logic                addr_ok;

    reg16_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // While locked only the owner may win; the round-robin pick is ignored.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = owner_q;
        ack       = '0;
        if (state_q == StIdle) begin
            gnt_valid = pick_any;
            gnt_idx   = pick_idx;
            ack       = pick_gnt;
        end else if (req[owner_q]) begin
            gnt_valid      = 1'b1;
            ack[owner_q]   = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                sel_addr = addr[i*ADDR_W +: ADDR_W];
                sel_data = wdata[i*DATA_W +: DATA_W];
                sel_lock = lock[i];
            end
        end
    end

    always_comb begin
        addr_ok = ({1'b0, sel_addr} < NumRegsW);
        we_d    = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            we_d[r] = gnt_valid && addr_ok && (sel_addr == ADDR_W'(r));
        end
        err_d   = gnt_valid && !addr_ok;
        d_out_d = gnt_valid ? sel_data : d_out_q;
        owner_d = gnt_valid ? gnt_idx : owner_q;

        rr_d    = rr_q;
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    rr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    if (sel_lock) begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (gnt_valid && !sel_lock) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            rr_q    <= '0;
            owner_q <= '0;
            we_q    <= '0;
            d_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            d_out_q <= d_out_d;
            err_q   <= err_d;
        end
    end

    assign we       = we_q;
    assign d_out    = d_out_q;
    assign owner    = owner_q;
    assign locked   = (state_q == StLocked);
    assign err_addr = err_q;

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Scoreboard bench for reg16_write_arbiter: stimulus pushes expected bank writes,
// monitors pop and compare whenever the DUT presents a write or address error.
module tb_reg16_write_arbiter;

    typedef struct packed {
        logic [7:0]  we;
        logic [15:0] d;
        logic [1:0]  owner;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: NUM_REGS = 8
    logic [3:0]  req = '0, lock = '0, ack;
    logic [11:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  we;
    logic [15:0] d_out;
    logic [1:0]  owner;
    logic        locked, err_addr;

    // Second instance: NUM_REGS = 6 so address 7 is out of range
    logic [3:0]  req6 = '0, lock6 = '0, ack6;
    logic [11:0] addr6 = '0;
    logic [63:0] wdata6 = '0;
    logic [5:0]  we6;
    logic [15:0] d6;
    logic [1:0]  owner6;
    logic        locked6, err6;

    reg16_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3)) u_dut (
        .CLK(clk), .RST(rst), .req(req), .lock(lock), .addr(addr), .wdata(wdata),
        .ack(ack), .we(we), .d_out(d_out), .owner(owner), .locked(locked),
        .err_addr(err_addr)
    );

    reg16_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3)) u_dut6 (
        .CLK(clk), .RST(rst), .req(req6), .lock(lock6), .addr(addr6), .wdata(wdata6),
        .ack(ack6), .we(we6), .d_out(d6), .owner(owner6), .locked(locked6),
        .err_addr(err6)
    );

    exp_t q[$];
    exp_t q6[$];
    exp_t mon_e, mon_e6;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (we !== 8'h00 || err_addr !== 1'b0)) begin
            if (q.size() == 0) begin
                check("unexpected_write", {we, d_out, owner, err_addr}, 64'h0);
            end else begin
                mon_e = q.pop_front();
                check("write", {we, d_out, owner, err_addr}, mon_e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (we6 !== 6'h00 || err6 !== 1'b0)) begin
            if (q6.size() == 0) begin
                check("unexpected_write6", {we6, d6, owner6, err6}, 64'h0);
            end else begin
                mon_e6 = q6.pop_front();
                check("write6", {2'b00, we6, d6, owner6, err6}, mon_e6);
            end
        end
    end

    // Called at a falling edge with inputs already driven.
    task automatic step(input int exp_idx, input string nm);
        logic [3:0] ea;
        logic [2:0] a;
        exp_t       e;
        #1;
        ea = (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx);
        check(nm, ack, ea);
        if (exp_idx >= 0) begin
            a       = addr[exp_idx*3 +: 3];
            e.we    = 8'(1) << a;
            e.d     = wdata[exp_idx*16 +: 16];
            e.owner = 2'(exp_idx);
            e.err   = 1'b0;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic step6(input int exp_idx, input exp_t e, input string nm);
        #1;
        check(nm, ack6, (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx));
        if (exp_idx >= 0) q6.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            check("reset_state", {we, d_out, owner, locked, err_addr}, 64'h0);
            step(-1, "reset_noack");
        end

        // Single write from requester 1
        req = 4'b0010; addr[3 +: 3] = 3'd5; wdata[16 +: 16] = 16'hBEEF;
        step(1, "single_ack");
        req = 4'b0000;
        check("single_we_literal", we, 8'b0010_0000);
        step(-1, "single_noack");

        // Async reset mid-cycle while a write is on the bank port
        req = 4'b0010; wdata[16 +: 16] = 16'hCAFE;
        step(1, "pre_rst_ack");
        req = 4'b0000;
        #2 rst = 1'b1;
        #1 check("async_rst", {we, d_out, owner, locked, err_addr}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all four requesting from pointer 0
        for (int i = 0; i < 4; i++) begin
            addr[i*3 +: 3]   = 3'(2 * i);
            wdata[i*16 +: 16] = 16'h1000 + 16'(i);
        end
        req = 4'b1111;
        step(0, "rr0"); step(1, "rr1"); step(2, "rr2"); step(3, "rr3");
        step(0, "rr4"); step(1, "rr5"); step(2, "rr6"); step(3, "rr7");
        req = 4'b0000;
        step(-1, "rr_idle");

        // Locked burst from 0 with requester 2 waiting; pointer is 0 here
        req = 4'b0101; lock = 4'b0001;
        addr[0 +: 3] = 3'd1; wdata[0 +: 16] = 16'hA001;
        addr[6 +: 3] = 3'd7; wdata[32 +: 16] = 16'hC002;
        check("burst_locked0", locked, 1'b0);
        step(0, "burst_w1");
        check("burst_locked1", locked, 1'b1);
        wdata[0 +: 16] = 16'hA002;
        step(0, "burst_w2");
        req = 4'b0100;
        step(-1, "burst_owner_gap");
        check("burst_locked_gap", locked, 1'b1);
        req = 4'b0101; wdata[0 +: 16] = 16'hA003;
        step(0, "burst_w3");
        lock = 4'b0000; wdata[0 +: 16] = 16'hA004;
        step(0, "burst_w4_last");
        req = 4'b0100;
        check("burst_unlocked", locked, 1'b0);
        step(2, "burst_req2");
        req = 4'b0000;
        step(-1, "burst_idle");

        // Out-of-range address on the six-register bank, then a normal write
        req6 = 4'b0001; addr6[0 +: 3] = 3'd7; wdata6[0 +: 16] = 16'h1234;
        e = '{we: 8'h00, d: 16'h1234, owner: 2'd0, err: 1'b1};
        step6(0, e, "oor_ack");
        addr6[0 +: 3] = 3'd3; wdata6[0 +: 16] = 16'h5678;
        e = '{we: 8'b0000_1000, d: 16'h5678, owner: 2'd0, err: 1'b0};
        step6(0, e, "oor_next_ack");
        req6 = 4'b0000;
        step6(-1, e, "oor_idle");

        // Reset while locked with a grant pending; pointer was 3 before the burst
        req = 4'b0010; lock = 4'b0010; addr[3 +: 3] = 3'd2; wdata[16 +: 16] = 16'h7777;
        step(1, "lk_first");
        check("lk_locked", locked, 1'b1);
        #1 check("lk_pending_ack", ack, 4'b0010);
        #2 rst = 1'b1;
        #1 check("lk_rst_clear", {we, locked}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1010; lock = 4'b0000; addr[9 +: 3] = 3'd4; wdata[48 +: 16] = 16'h3333;
        step(1, "post_rst_ptr0");
        req = 4'b0000;
        step(-1, "post_rst_idle");
        step(-1, "final_idle");

        check("queue_drained", 64'(q.size()), 64'h0);
        check("queue6_drained", 64'(q6.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
